rob_superscalar: RTL and testbench

- Parametrised, N-wide successor to the single-issue ROB in the dispatch/issue stage.
- Allocates up to DP_WIDTH entries per cycle in program order.
- Accepts up to CDB_PORTS completions per cycle and retires up to RT_WIDTH completed entries per cycle in order.
- Generates a squash when a mispredicted branch retires. Sits between decode/dispatch, the reservation stations/map table and the architectural register file.

---
 rtl/rob_superscalar_if.sv | 46 ++++
 rtl/rob_superscalar.sv | 142 ++++++++++++++
 tb/tb_rob_superscalar.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_superscalar_if.sv
// Dispatch, completion-broadcast and retire bundle of the superscalar reorder buffer.
// The master side is the pipeline around the ROB. The slave side is the ROB itself.
interface rob_superscalar_if #(
  parameter int ROB_DEPTH = 32,
  parameter int DP_WIDTH  = 2,
  parameter int RT_WIDTH  = 2,
  parameter int CDB_PORTS = 2,
  parameter int REG_IDX_W = 5,
  parameter int PC_W      = 32
);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  logic                                 stall;
  logic [DP_WIDTH-1:0]                  dp_valid;
  logic [DP_WIDTH-1:0][REG_IDX_W-1:0]   dp_dest_reg;
  logic [DP_WIDTH-1:0][PC_W-1:0]        dp_pc;
  logic [DP_WIDTH-1:0]                  dp_is_branch;
  logic [DP_WIDTH-1:0][TAG_W-1:0]       dp_tag;
  logic                                 dp_stall;
  logic [CDB_PORTS-1:0]                 cdb_valid;
  logic [CDB_PORTS-1:0][TAG_W-1:0]      cdb_tag;
  logic [CDB_PORTS-1:0]                 cdb_mispredict;
  logic [CDB_PORTS-1:0][PC_W-1:0]       cdb_target;
  logic [RT_WIDTH-1:0]                  rt_valid;
  logic [RT_WIDTH-1:0][REG_IDX_W-1:0]   rt_dest_reg;
  logic [RT_WIDTH-1:0][TAG_W-1:0]       rt_tag;
  logic [RT_WIDTH-1:0][PC_W-1:0]        rt_pc;
  logic                                 squash;
  logic [PC_W-1:0]                      squash_pc;
  logic [TAG_W:0]                       count;
  logic                                 empty;

  modport master (
    output stall, dp_valid, dp_dest_reg, dp_pc, dp_is_branch,
    output cdb_valid, cdb_tag, cdb_mispredict, cdb_target,
    input  dp_tag, dp_stall, rt_valid, rt_dest_reg, rt_tag, rt_pc,
    input  squash, squash_pc, count, empty
  );

  modport slave (
    input  stall, dp_valid, dp_dest_reg, dp_pc, dp_is_branch,
    input  cdb_valid, cdb_tag, cdb_mispredict, cdb_target,
    output dp_tag, dp_stall, rt_valid, rt_dest_reg, rt_tag, rt_pc,
    output squash, squash_pc, count, empty
  );
endinterface

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: in-order multi-slot allocate, multi-port completion,
// in-order multi-slot retire, and a full flush when a mispredicted branch retires.
module rob_superscalar #(
  parameter int ROB_DEPTH = 32,
  parameter int DP_WIDTH  = 2,
  parameter int RT_WIDTH  = 2,
  parameter int CDB_PORTS = 2,
  parameter int REG_IDX_W = 5,
  parameter int PC_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  rob_superscalar_if.slave   bus
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int PTR_W = TAG_W + 1;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [ROB_DEPTH-1:0] r_valid, r_complete, r_is_branch, r_mispred;
  logic [REG_IDX_W-1:0] r_dest   [ROB_DEPTH];
  logic [PC_W-1:0]      r_pc     [ROB_DEPTH];
  logic [PC_W-1:0]      r_target [ROB_DEPTH];
  ptr_t                 r_head, r_tail;

  ptr_t                 w_count, w_n_alloc, w_n_retire;
  logic                 w_dp_stall, w_alloc_en, w_squash;
  logic [PC_W-1:0]      w_squash_pc;
  logic [RT_WIDTH-1:0]  w_rt_valid;
  tag_t                 w_dp_idx [DP_WIDTH];
  tag_t                 w_rt_idx [RT_WIDTH];

  // The pointer wrap bit makes tail-head the exact occupancy, full included.
  assign w_count    = r_tail - r_head;
  assign w_dp_stall = (PTR_W'(ROB_DEPTH) - w_count) < PTR_W'(DP_WIDTH);
  assign w_alloc_en = !bus.stall && !w_dp_stall && !w_squash;

  always_comb begin
    for (int i = 0; i < DP_WIDTH; i++) w_dp_idx[i] = r_tail[TAG_W-1:0] + TAG_W'(i);
    for (int j = 0; j < RT_WIDTH; j++) w_rt_idx[j] = r_head[TAG_W-1:0] + TAG_W'(j);
  end

  // Only the leading contiguous run of requesting slots is accepted.
  always_comb begin : alloc_count
    logic run;
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    run       = 1'b1;
    w_n_alloc = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      if (run && bus.dp_valid[i]) w_n_alloc = w_n_alloc + PTR_W'(1);
      else                        run       = 1'b0;
    end
    if (!w_alloc_en) w_n_alloc = '0;
  end

  always_comb begin : retire_select
    logic go;
    go              = 1'b1;
    w_rt_valid      = '0;
    w_n_retire      = '0;
    w_squash        = 1'b0;
    w_squash_pc     = '0;
    bus.rt_dest_reg = '0;
    bus.rt_tag      = '0;
    bus.rt_pc       = '0;
    for (int j = 0; j < RT_WIDTH; j++) begin
      if (go && r_valid[w_rt_idx[j]] && r_complete[w_rt_idx[j]]) begin
        w_rt_valid[j]      = 1'b1;
        w_n_retire         = w_n_retire + PTR_W'(1);
        bus.rt_dest_reg[j] = r_dest[w_rt_idx[j]];
        bus.rt_tag[j]      = w_rt_idx[j];
        bus.rt_pc[j]       = r_pc[w_rt_idx[j]];
        // A mispredicted branch is the last instruction allowed to retire.
        if (r_mispred[w_rt_idx[j]]) begin
          w_squash    = 1'b1;
          w_squash_pc = r_target[w_rt_idx[j]];
          go          = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<='; later writes in the same block win, so CDB ports are walked highest first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid    <= '0;
      r_complete <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (w_squash) begin
      r_valid    <= '0;
      r_complete <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      for (int p = CDB_PORTS - 1; p >= 0; p--)
        if (bus.cdb_valid[p] && r_valid[bus.cdb_tag[p]]) r_complete[bus.cdb_tag[p]] <= 1'b1;
      for (int i = 0; i < DP_WIDTH; i++)
        if (PTR_W'(i) < w_n_alloc) begin
          r_valid[w_dp_idx[i]]    <= 1'b1;
          r_complete[w_dp_idx[i]] <= 1'b0;
        end
      for (int j = 0; j < RT_WIDTH; j++)
        if (w_rt_valid[j]) begin
          r_valid[w_rt_idx[j]]    <= 1'b0;
          r_complete[w_rt_idx[j]] <= 1'b0;
        end
      r_head <= r_head + w_n_retire;
      r_tail <= r_tail + w_n_alloc;
    end
  end

  // NOTE: payload storage has no reset; it is only observed through the reset valid/complete flags.
  always_ff @(posedge clock) begin
    for (int p = CDB_PORTS - 1; p >= 0; p--)
      if (bus.cdb_valid[p] && r_valid[bus.cdb_tag[p]]) begin
        // Only a branch can redirect fetch; a stray mispredict on anything else is dropped.
        r_mispred[bus.cdb_tag[p]] <= bus.cdb_mispredict[p] & r_is_branch[bus.cdb_tag[p]];
        r_target[bus.cdb_tag[p]]  <= bus.cdb_target[p];
      end
    for (int i = 0; i < DP_WIDTH; i++)
      if (PTR_W'(i) < w_n_alloc) begin
        r_dest[w_dp_idx[i]]      <= bus.dp_dest_reg[i];
        r_pc[w_dp_idx[i]]        <= bus.dp_pc[i];
        r_is_branch[w_dp_idx[i]] <= bus.dp_is_branch[i];
        r_mispred[w_dp_idx[i]]   <= 1'b0;
      end
  end

  always_comb begin
    for (int i = 0; i < DP_WIDTH; i++) bus.dp_tag[i] = w_dp_idx[i];
  end

  assign bus.dp_stall  = w_dp_stall;
  assign bus.rt_valid  = w_rt_valid;
  assign bus.squash    = w_squash;
  assign bus.squash_pc = w_squash_pc;
  assign bus.count     = w_count;
  assign bus.empty     = (w_count == '0);
endmodule

// File: tb/tb_rob_superscalar.sv
// Randomised scoreboard bench for rob_superscalar: an in-order queue model predicts
// each cycle's status and retire stream, and a negedge monitor compares the DUT.
module tb_rob_superscalar;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rob_superscalar_if #(.ROB_DEPTH(DEPTH)) bus ();
  rob_superscalar #(.ROB_DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] pc;
    bit          br;
    bit          done;
    bit          misp;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] pc;
  } rt_t;

  typedef struct {
    int          cnt;
    bit          dstall;
    int          tail;
    int          n_rt;
    bit          sq;
    logic [31:0] spc;
  } st_t;

  ent_t rob_q[$];
  rt_t  rt_q[$];
  st_t  st_q[$];
  int   tail_ptr = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes the predictions that the driver queued for this cycle.
  always @(negedge clock) begin
    if (reset && st_q.size() > 0) begin
      st_t s;
      int  nv;
      s  = st_q.pop_front();
      nv = $countones(bus.rt_valid);
      check("count",     64'(bus.count),     64'(s.cnt));
      check("empty",     64'(bus.empty),     64'(s.cnt == 0));
      check("dp_stall",  64'(bus.dp_stall),  64'(s.dstall));
      check("dp_tag0",   64'(bus.dp_tag[0]), 64'(s.tail % DEPTH));
      check("dp_tag1",   64'(bus.dp_tag[1]), 64'((s.tail + 1) % DEPTH));
      check("rt_num",    64'(nv),            64'(s.n_rt));
      check("squash",    64'(bus.squash),    64'(s.sq));
      if (s.sq) check("squash_pc", 64'(bus.squash_pc), 64'(s.spc));
      for (int j = 0; j < 2; j++) begin
        if (bus.rt_valid[j]) begin
          if (rt_q.size() == 0) begin
            check("rt_unexpected", 64'(j), 64'hFFFF);
          end else begin
            rt_t r;
            r = rt_q.pop_front();
            check("rt_tag",  64'(bus.rt_tag[j]),      64'(r.tag));
            check("rt_dest", 64'(bus.rt_dest_reg[j]), 64'(r.dest));
            check("rt_pc",   64'(bus.rt_pc[j]),       64'(r.pc));
          end
        end
      end
    end
  end

  // One cycle: predict this cycle's outputs from the model, drive random stimulus,
  // then advance the model across the coming edge.
  task automatic step(input int p_dp, input int p_cdb, input int p_stall);
    st_t s;
    int  n_rt;
    bit  sq;
    @(posedge clock);
    #1;
    s.cnt    = rob_q.size();
    s.dstall = (DEPTH - s.cnt) < 2;
    s.tail   = tail_ptr;
    n_rt     = 0;
    sq       = 1'b0;
    s.spc    = '0;
    for (int j = 0; j < 2 && j < rob_q.size(); j++) begin
      rt_t r;
      if (!rob_q[j].done) break;
      r.tag  = rob_q[j].tag;
      r.dest = rob_q[j].dest;
      r.pc   = rob_q[j].pc;
      rt_q.push_back(r);
      n_rt++;
      if (rob_q[j].misp) begin
        sq    = 1'b1;
        s.spc = rob_q[j].tgt;
        break;
      end
    end
    s.n_rt = n_rt;
    s.sq   = sq;
    st_q.push_back(s);

    bus.stall = ($urandom_range(0, 99) < p_stall);
    for (int i = 0; i < 2; i++) begin
      bus.dp_valid[i]     = ($urandom_range(0, 99) < p_dp);
      bus.dp_dest_reg[i]  = 5'($urandom);
      bus.dp_pc[i]        = $urandom;
      bus.dp_is_branch[i] = ($urandom_range(0, 3) == 0);
    end
    for (int p = 0; p < 2; p++) begin
      bus.cdb_valid[p]      = ($urandom_range(0, 99) < p_cdb);
      bus.cdb_target[p]     = $urandom;
      bus.cdb_mispredict[p] = 1'b0;
      if (rob_q.size() > 0 && $urandom_range(0, 7) != 0) begin
        int k;
        k = $urandom_range(0, rob_q.size() - 1);
        bus.cdb_tag[p]        = 5'(rob_q[k].tag);
        bus.cdb_mispredict[p] = rob_q[k].br && ($urandom_range(0, 3) == 0);
      end else begin
        bus.cdb_tag[p] = 5'($urandom);
      end
    end

    if (sq) begin
      rob_q.delete();
      tail_ptr = 0;
    end else begin
      repeat (n_rt) void'(rob_q.pop_front());
      // Walk ports highest first so the lowest-index port has the final say.
      for (int p = 1; p >= 0; p--) begin
        if (bus.cdb_valid[p]) begin
          foreach (rob_q[k]) begin
            if (rob_q[k].tag == int'(bus.cdb_tag[p])) begin
              rob_q[k].done = 1'b1;
              rob_q[k].misp = bus.cdb_mispredict[p];
              rob_q[k].tgt  = bus.cdb_target[p];
            end
          end
        end
      end
      if (!bus.stall && !s.dstall) begin
        for (int i = 0; i < 2; i++) begin
          ent_t e;
          if (!bus.dp_valid[i]) break;
          e.tag  = tail_ptr;
          e.dest = bus.dp_dest_reg[i];
          e.pc   = bus.dp_pc[i];
          e.br   = bus.dp_is_branch[i];
          e.done = 1'b0;
          e.misp = 1'b0;
          e.tgt  = '0;
          rob_q.push_back(e);
          tail_ptr = (tail_ptr + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_count"},    64'(bus.count),     64'd0);
    check({tagname, "_empty"},    64'(bus.empty),     64'd1);
    check({tagname, "_rt_valid"}, 64'(bus.rt_valid),  64'd0);
    check({tagname, "_squash"},   64'(bus.squash),    64'd0);
    check({tagname, "_sq_pc"},    64'(bus.squash_pc), 64'd0);
    check({tagname, "_dp_stall"}, 64'(bus.dp_stall),  64'd0);
    check({tagname, "_dp_tag0"},  64'(bus.dp_tag[0]), 64'd0);
    check({tagname, "_dp_tag1"},  64'(bus.dp_tag[1]), 64'd1);
  endtask

  initial begin
    bus.stall          = 1'b0;
    bus.dp_valid       = '0;
    bus.dp_dest_reg    = '0;
    bus.dp_pc          = '0;
    bus.dp_is_branch   = '0;
    bus.cdb_valid      = '0;
    bus.cdb_tag        = '0;
    bus.cdb_mispredict = '0;
    bus.cdb_target     = '0;
    #3;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b1;

    // Fill with no completions: occupancy saturates at 32 and dp_stall holds it there.
    repeat (20) step(100, 0, 0);
    // Mixed random traffic: completions, stalls, squashes and pointer wrap.
    repeat (400) step(70, 60, 15);
    // Build occupancy back up, then reset asynchronously mid-cycle.
    for (int n = 0; n < 20 && rob_q.size() < 10; n++) step(100, 0, 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    rob_q.delete();
    rt_q.delete();
    st_q.delete();
    tail_ptr = 0;
    @(negedge clock);
    reset = 1'b1;
    // Steady allocate/retire traffic with eager completion.
    repeat (120) step(100, 95, 0);
    repeat (200) step(60, 80, 10);
    @(negedge clock);
    #1;
    check("rt_q_drained", 64'(rt_q.size()), 64'd0);
    check("st_q_drained", 64'(st_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
